// File: rtl/lcd_pixel_stream_if.sv
// Byte stream from the pixel formatter to the TFT bus driver.
//   byte_data  : RGB565 byte, high byte of each pixel first
//   byte_valid : byte_data / byte_sof are valid
//   byte_ready : consumer takes the byte on byte_valid && byte_ready
//   byte_sof   : marks the high byte of pixel 0 of a frame
// master = formatter side, slave = bus driver side.
interface lcd_pixel_stream_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_sof;

    modport master (
        output byte_data,
        output byte_valid,
        output byte_sof,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  byte_sof,
        output byte_ready
    );
endinterface

// File: rtl/lcd_pixel_stream.sv
// Pixel formatter between the Game Boy LCD output and the TFT bus driver.
// Maps 2-bit colour indices through the BGP palette to greyscale RGB565,
// buffers them in a small FIFO and sends them as high/low bytes on a
// valid/ready stream. Tracks frames on lcd_vblank, tags the first byte of
// each frame and flags dropped pixels and malformed frames.
//
// Ports:
//   clk, reset_n   : single clock, async active-low reset
//   lcd_write      : one-cycle pixel strobe, lcd_col valid with it
//   lcd_col        : 2-bit colour index
//   lcd_vblank     : level, high during vertical blank
//   palette        : BGP format, index i -> shade palette[2i+1:2i]
//   bus            : byte stream (master side)
//   overflow       : sticky, a pixel was dropped on a full FIFO
//   frame_err      : sticky, a frame had a pixel count other than W*H
//   fifo_level     : current FIFO occupancy
//
// Serializer states:
//   state  | meaning
//   S_IDLE | nothing on the bus, waiting for a FIFO entry
//   S_HI   | high byte of the current pixel presented
//   S_LO   | low byte of the current pixel presented
module lcd_pixel_stream #(
    parameter int FIFO_DEPTH = 16,
    parameter int LCD_W      = 160,
    parameter int LCD_H      = 144
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          lcd_write,
    input  logic [1:0]                    lcd_col,
    input  logic                          lcd_vblank,
    input  logic [7:0]                    palette,
    lcd_pixel_stream_if.master            bus,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int PW        = AW + 1;
    localparam int FRAME_PIX = LCD_W * LCD_H;
    localparam int CW        = $clog2(FRAME_PIX + 1);
    localparam logic [CW-1:0] FRAME_MAX = CW'(FRAME_PIX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    function automatic logic [15:0] shade_rgb(input logic [1:0] shade);
        case (shade)
            2'd0:    shade_rgb = 16'hFFFF;
            2'd1:    shade_rgb = 16'hAD55;
            2'd2:    shade_rgb = 16'h52AA;
            default: shade_rgb = 16'h0000;
        endcase
    endfunction

    // ---------------- pixel FIFO: {sof, shade} per entry ----------------
    logic [2:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [2:0]    head;
    logic [1:0]    wr_shade;
    logic          wr_sof;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push       = lcd_write && (!fifo_full || pop);

    // ---------------- frame pixel counter ----------------
    logic [CW-1:0] pix_cnt;
    logic [CW:0]   final_cnt;
    logic          vb_q;
    logic          vb_rise;
    logic          pix_sat;
    logic          short_frame;
    logic          extra_pix;

    assign vb_rise   = lcd_vblank && !vb_q;
    assign pix_sat   = (pix_cnt == FRAME_MAX);
    assign wr_sof    = (pix_cnt == '0);
    assign wr_shade  = palette[{lcd_col, 1'b0} +: 2];

    // A pixel arriving with the vblank edge still belongs to the old frame.
    assign final_cnt   = {1'b0, pix_cnt} + {{CW{1'b0}}, lcd_write};
    assign short_frame = vb_rise && (final_cnt != '0) &&
                         (final_cnt != {1'b0, FRAME_MAX});
    assign extra_pix   = lcd_write && pix_sat;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wr_sof, wr_shade};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vb_q      <= 1'b0;
            pix_cnt   <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            vb_q <= lcd_vblank;
            if (vb_rise) begin
                pix_cnt <= '0;
            end else if (lcd_write && !pix_sat) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (lcd_write && fifo_full && !pop) overflow  <= 1'b1;
            if (short_frame || extra_pix)       frame_err <= 1'b1;
        end
    end

    // ---------------- serializer ----------------
    state_t      state;
    state_t      state_d;
    logic [7:0]  data_q;
    logic [7:0]  data_d;
    logic [7:0]  lo_q;
    logic [7:0]  lo_d;
    logic        sof_q;
    logic        sof_d;
    logic [15:0] head_rgb;

    assign head_rgb = shade_rgb(head[1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            data_q <= 8'h00;
            lo_q   <= 8'h00;
            sof_q  <= 1'b0;
        end else begin
            state  <= state_d;
            data_q <= data_d;
            lo_q   <= lo_d;
            sof_q  <= sof_d;
        end
    end

    always_comb begin
        state_d = state;
        data_d  = data_q;
        lo_d    = lo_q;
        sof_d   = sof_q;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = head_rgb[15:8];
                    lo_d    = head_rgb[7:0];
                    sof_d   = head[2];
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (bus.byte_ready) begin
                    data_d  = lo_q;
                    sof_d   = 1'b0;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (bus.byte_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = head_rgb[15:8];
                        lo_d    = head_rgb[7:0];
                        sof_d   = head[2];
                        state_d = S_HI;
                    end else begin
                        data_d  = 8'h00;
                        sof_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.byte_valid = (state != S_IDLE);
    assign bus.byte_data  = data_q;
    assign bus.byte_sof   = sof_q;

endmodule

// File: tb/tb_lcd_pixel_stream.sv
module tb_lcd_pixel_stream;

    localparam int D     = 16;
    localparam int FRAME = 160 * 144;

    logic                 clk        = 1'b0;
    logic                 reset_n    = 1'b0;
    logic                 lcd_write  = 1'b0;
    logic [1:0]           lcd_col    = 2'd0;
    logic                 lcd_vblank = 1'b0;
    logic [7:0]           palette    = 8'hE4;
    logic                 overflow;
    logic                 frame_err;
    logic [$clog2(D):0]   fifo_level;

    lcd_pixel_stream_if bus();

    lcd_pixel_stream #(.FIFO_DEPTH(D), .LCD_W(160), .LCD_H(144)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lcd_write  (lcd_write),
        .lcd_col    (lcd_col),
        .lcd_vblank (lcd_vblank),
        .palette    (palette),
        .bus        (bus),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          n_acc      = 0;
    int          n_rx_bytes = 0;
    int          tb_pix     = 0;
    bit          stab_en    = 1'b0;
    bit          stalled    = 1'b0;
    logic [8:0]  last_stall = 9'h0;
    logic [8:0]  rx_q [$];
    logic [8:0]  exp_q [$];
    logic [15:0] shade_tab [4] = '{16'hFFFF, 16'hAD55, 16'h52AA, 16'h0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    endtask

    // Byte monitor and stall-stability check, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n && bus.byte_valid && bus.byte_ready) begin
            rx_q.push_back({bus.byte_sof, bus.byte_data});
            n_rx_bytes++;
        end
        if (stab_en && reset_n && stalled)
            chk("stall_hold", {23'd0, bus.byte_valid, bus.byte_sof, bus.byte_data},
                {23'd0, 1'b1, last_stall});
        stalled    = reset_n && bus.byte_valid && !bus.byte_ready;
        last_stall = {bus.byte_sof, bus.byte_data};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        lcd_write = 1'b0;
        repeat (n) step();
    endtask

    // One pixel strobe; the model records its bytes when it is expected to be kept.
    task automatic pix(input logic [1:0] col, input bit keep);
        int          sh;
        logic [15:0] rgb;
        sh  = (int'(palette) >> (2 * int'(col))) & 3;
        rgb = shade_tab[sh];
        lcd_col   = col;
        lcd_write = 1'b1;
        if (keep) begin
            exp_q.push_back({(tb_pix == 0), rgb[15:8]});
            exp_q.push_back({1'b0, rgb[7:0]});
            n_acc++;
        end
        tb_pix++;
        step();
    endtask

    task automatic check_stream(input string tag, input int budget);
        int waited = 0;
        lcd_write = 1'b0;
        while (rx_q.size() < exp_q.size() && waited < budget) begin
            step();
            waited++;
        end
        repeat (4) step();
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk(tag, {23'd0, rx_q[i]}, {23'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        lcd_write  = 1'b0;
        lcd_vblank = 1'b0;
        reset_n    = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        tb_pix  = 0;
        step();
        rx_q.delete();
        exp_q.delete();
    endtask

    function automatic int count_sof();
        int n = 0;
        foreach (rx_q[i]) if (rx_q[i][8]) n++;
        return n;
    endfunction

    initial begin
        logic [3:0] pat;
        bus.byte_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, bus.byte_valid}, 0);
        chk("rst_data", {24'd0, bus.byte_data}, 0);
        chk("rst_sof", {31'd0, bus.byte_sof}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_level", {27'd0, fifo_level}, 0);
        reset_n = 1'b1;
        step();

        // Single pixel latency: E4, col 2 -> 52AA, sof on pixel 0
        palette   = 8'hE4;
        lcd_col   = 2'd2;
        lcd_write = 1'b1;
        tb_pix++;
        step();
        lcd_write = 1'b0;
        chk("lat_n1_valid", {31'd0, bus.byte_valid}, 0);
        step();
        chk("lat_n2_valid", {31'd0, bus.byte_valid}, 1);
        chk("lat_n2_data", {24'd0, bus.byte_data}, 32'h52);
        chk("lat_n2_sof", {31'd0, bus.byte_sof}, 1);
        step();
        chk("lat_n3_valid", {31'd0, bus.byte_valid}, 1);
        chk("lat_n3_data", {24'd0, bus.byte_data}, 32'hAA);
        chk("lat_n3_sof", {31'd0, bus.byte_sof}, 0);
        step();
        chk("lat_n4_valid", {31'd0, bus.byte_valid}, 0);
        rx_q.delete();

        // Palette remap, palette scrambled after every write
        for (int c = 0; c < 4; c++) begin
            palette = 8'h1B;
            pix(2'(c), 1'b1);
            palette = 8'($urandom);
        end
        check_stream("remap", 40);

        // Backpressure 1-0-0-1
        stab_en = 1'b1;
        palette = 8'hE4;
        pat     = 4'b1001;
        for (int i = 0; i < 4; i++) pix(2'($urandom_range(0, 3)), 1'b1);
        lcd_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.byte_ready = pat[i % 4];
            step();
        end
        bus.byte_ready = 1'b1;
        check_stream("backpressure", 40);
        chk("bp_overflow", {31'd0, overflow}, 0);

        // Reset in the middle of a pixel
        bus.byte_ready = 1'b0;
        pix(2'd1, 1'b0);
        idle(3);
        chk("midrst_valid_before", {31'd0, bus.byte_valid}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid_async", {31'd0, bus.byte_valid}, 0);
        chk("midrst_data_async", {24'd0, bus.byte_data}, 0);
        step();
        reset_n        = 1'b1;
        tb_pix         = 0;
        bus.byte_ready = 1'b1;
        idle(6);
        chk("midrst_no_bytes", rx_q.size(), 0);
        chk("midrst_level", {27'd0, fifo_level}, 0);
        rx_q.delete();

        // Randomized traffic against the model, never allowed to fill the FIFO
        n_acc      = 0;
        n_rx_bytes = 0;
        for (int i = 0; i < 500; i++) begin
            bus.byte_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && (n_acc - n_rx_bytes / 2) < D - 1) begin
                palette = 8'($urandom);
                pix(2'($urandom_range(0, 3)), 1'b1);
            end else begin
                idle(1);
            end
        end
        bus.byte_ready = 1'b1;
        check_stream("random", 200);
        stab_en = 1'b0;

        // Overflow: serializer stalled on a sentinel, then D+3 pixels
        bus.byte_ready = 1'b0;
        palette        = 8'hE4;
        pix(2'd3, 1'b1);
        idle(3);
        for (int i = 0; i < D + 3; i++) begin
            pix(2'($urandom_range(0, 3)), (i < D));
            if (i == D - 1) begin
                chk("ovf_level_full", {27'd0, fifo_level}, D);
                chk("ovf_not_yet", {31'd0, overflow}, 0);
            end
        end
        idle(2);
        chk("ovf_level", {27'd0, fifo_level}, D);
        chk("ovf_flag", {31'd0, overflow}, 1);
        bus.byte_ready = 1'b1;
        check_stream("ovf_stream", 100);
        chk("ovf_level_drained", {27'd0, fifo_level}, 0);
        chk("ovf_sticky", {31'd0, overflow}, 1);

        // Full frame then a short frame
        do_reset();
        for (int i = 0; i < FRAME; i++) pix(2'($urandom_range(0, 3)), 1'b0);
        lcd_write  = 1'b0;
        lcd_vblank = 1'b1;
        step();
        chk("full_frame_err", {31'd0, frame_err}, 0);
        idle(40);
        chk("full_frame_sof_count", count_sof(), 1);
        rx_q.delete();
        lcd_vblank = 1'b0;
        step();
        for (int i = 0; i < FRAME - 1; i++) pix(2'($urandom_range(0, 3)), 1'b0);
        chk("next_frame_first_sof", (rx_q.size() > 0) ? {31'd0, rx_q[0][8]} : 32'd0, 1);
        lcd_write = 1'b0;
        chk("short_before_edge", {31'd0, frame_err}, 0);
        lcd_vblank = 1'b1;
        step();
        chk("short_frame_err", {31'd0, frame_err}, 1);
        idle(40);
        chk("short_frame_sof_count", count_sof(), 1);
        rx_q.delete();

        // Empty vblank, then pixel coincident with the edge completing the frame
        do_reset();
        lcd_vblank = 1'b1;
        step();
        step();
        chk("empty_frame_err", {31'd0, frame_err}, 0);
        lcd_vblank = 1'b0;
        step();
        for (int i = 0; i < FRAME - 1; i++) pix(2'($urandom_range(0, 3)), 1'b0);
        lcd_vblank = 1'b1;
        pix(2'($urandom_range(0, 3)), 1'b0);
        idle(3);
        chk("edge_pixel_frame_err", {31'd0, frame_err}, 0);
        idle(40);
        rx_q.delete();
        exp_q.delete();
        tb_pix     = 0;
        lcd_vblank = 1'b0;
        step();
        palette = 8'($urandom);
        pix(2'($urandom_range(0, 3)), 1'b1);
        check_stream("after_edge_frame", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
